// File: rtl/gpu_pkg.sv
// Shared types for the GPU rectangle engine and related raster blocks.
package gpu_pkg;

  localparam int COORD_W = 12;
  localparam int COLOR_W = 8;

  typedef enum logic {
    RECT_FILL    = 1'b0,
    RECT_OUTLINE = 1'b1
  } rect_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    FIN   = 2'd3
  } rect_state_e;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

endpackage

// File: rtl/gpu_rect_walker.sv
// Raster walker over a clipped box: tracks cur_x/cur_y and the row base
// address, optionally skipping interior pixels of middle rows (outline).
module gpu_rect_walker #(
  parameter int COORD_WIDTH = 12,
  parameter int ADDR_WIDTH  = 19,
  parameter int FRAME_WIDTH = 640
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  logic [COORD_WIDTH-1:0] i_x0,
  input  logic [COORD_WIDTH-1:0] i_x1,
  input  logic [COORD_WIDTH-1:0] i_y0,
  input  logic [COORD_WIDTH-1:0] i_y1,
  input  logic [ADDR_WIDTH-1:0]  i_row_base,
  input  logic                   i_advance,
  input  logic                   i_skip_interior,
  output logic [COORD_WIDTH-1:0] o_cur_x,
  output logic [ADDR_WIDTH-1:0]  o_row_base,
  output logic                   o_last
);

  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FRAME_WIDTH);

  logic [COORD_WIDTH-1:0] r_x0, r_x1, r_y0, r_y1;
  logic [COORD_WIDTH-1:0] r_cur_x, r_cur_y;
  logic [ADDR_WIDTH-1:0]  r_row_base;
  logic                   w_row_end;
  logic                   w_interior;

  assign w_row_end  = (r_cur_x == r_x1);
  assign w_interior = (r_cur_y != r_y0) && (r_cur_y != r_y1);

  // Walker state: load bounds, then step one pixel per advance.
  // On an interior row that is not at its end we are at x0, so jump to x1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0       <= '0;
      r_x1       <= '0;
      r_y0       <= '0;
      r_y1       <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_row_base <= '0;
    end else if (i_load) begin
      r_x0       <= i_x0;
      r_x1       <= i_x1;
      r_y0       <= i_y0;
      r_y1       <= i_y1;
      r_cur_x    <= i_x0;
      r_cur_y    <= i_y0;
      r_row_base <= i_row_base;
    end else if (i_advance) begin
      if (w_row_end) begin
        r_cur_x    <= r_x0;
        r_cur_y    <= r_cur_y + 1'b1;
        r_row_base <= r_row_base + ROW_STEP;
      end else if (i_skip_interior && w_interior) begin
        r_cur_x <= r_x1;
      end else begin
        r_cur_x <= r_cur_x + 1'b1;
      end
    end
  end

  assign o_cur_x    = r_cur_x;
  assign o_row_base = r_row_base;
  assign o_last     = w_row_end && (r_cur_y == r_y1);

endmodule

// File: rtl/axi4_lite_gpu_execute_rect_ext.sv
// GPU rectangle executor: latches operands, normalises and clips corners,
// then streams FILL or OUTLINE pixels into the framebuffer write port.
//   state | meaning
//   IDLE  | waiting for start
//   SETUP | normalise/clip corners, compute first row base
//   RUN   | emit one pixel per accepted write
//   FIN   | one-cycle done pulse
module axi4_lite_gpu_execute_rect_ext #(
  parameter int FRAME_WIDTH_SCALED  = 640,
  parameter int FRAME_HEIGHT_SCALED = 480,
  parameter int COORD_WIDTH         = 12,
  parameter int COLOR_WIDTH         = 8,
  parameter int FBUF_ADDR_WIDTH     = 19,
  parameter int FBUF_DATA_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       mode,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic                       left_valid,
  input  logic [COORD_WIDTH-1:0]     left_x,
  input  logic [COORD_WIDTH-1:0]     left_y,
  input  logic                       right_valid,
  input  logic [COORD_WIDTH-1:0]     right_x,
  input  logic [COORD_WIDTH-1:0]     right_y,
  input  logic                       color_valid,
  input  logic [COLOR_WIDTH-1:0]     color,
  input  logic                       fbuf_ready,
  output logic                       fbuf_en_wr,
  output logic                       fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);
  import gpu_pkg::*;

  localparam logic [COORD_WIDTH-1:0]     W_C   = COORD_WIDTH'(FRAME_WIDTH_SCALED);
  localparam logic [COORD_WIDTH-1:0]     H_C   = COORD_WIDTH'(FRAME_HEIGHT_SCALED);
  localparam logic [COORD_WIDTH-1:0]     W_M1  = COORD_WIDTH'(FRAME_WIDTH_SCALED - 1);
  localparam logic [COORD_WIDTH-1:0]     H_M1  = COORD_WIDTH'(FRAME_HEIGHT_SCALED - 1);
  localparam logic [FBUF_ADDR_WIDTH-1:0] ROW_W = FBUF_ADDR_WIDTH'(FRAME_WIDTH_SCALED);

  rect_state_e r_state, w_state_nxt;

  logic [COORD_WIDTH-1:0] r_lx, r_ly, r_rx, r_ry;
  logic [COLOR_WIDTH-1:0] r_col;
  logic                   r_l_seen, r_r_seen, r_c_seen;

  logic [COORD_WIDTH-1:0] r_ax, r_ay, r_bx, r_by;
  logic [COLOR_WIDTH-1:0] r_snap_col;
  rect_mode_e             r_mode;
  logic                   r_err;

  logic                       w_snap, w_err_nxt, w_outside, w_load;
  logic [COORD_WIDTH-1:0]     w_x0, w_x1, w_y0, w_y1, w_x1c, w_y1c;
  logic [FBUF_ADDR_WIDTH-1:0] w_row0;
  logic [COORD_WIDTH-1:0]     w_cur_x;
  logic [FBUF_ADDR_WIDTH-1:0] w_row_base;
  logic                       w_last, w_run;

  // Operand registers; a latch during a command only affects the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lx <= '0; r_ly <= '0; r_rx <= '0; r_ry <= '0; r_col <= '0;
      r_l_seen <= 1'b0; r_r_seen <= 1'b0; r_c_seen <= 1'b0;
    end else begin
      if (left_valid)  begin r_lx <= left_x;  r_ly <= left_y;  r_l_seen <= 1'b1; end
      if (right_valid) begin r_rx <= right_x; r_ry <= right_y; r_r_seen <= 1'b1; end
      if (color_valid) begin r_col <= color; r_c_seen <= 1'b1; end
    end
  end

  // Command snapshot taken when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ax <= '0; r_ay <= '0; r_bx <= '0; r_by <= '0;
      r_snap_col <= '0;
      r_mode     <= RECT_FILL;
    end else if (w_snap) begin
      r_ax <= r_lx; r_ay <= r_ly; r_bx <= r_rx; r_by <= r_ry;
      r_snap_col <= r_col;
      r_mode     <= rect_mode_e'(mode);
    end
  end

  assign w_x0      = (r_ax < r_bx) ? r_ax : r_bx;
  assign w_x1      = (r_ax < r_bx) ? r_bx : r_ax;
  assign w_y0      = (r_ay < r_by) ? r_ay : r_by;
  assign w_y1      = (r_ay < r_by) ? r_by : r_ay;
  assign w_x1c     = (w_x1 > W_M1) ? W_M1 : w_x1;
  assign w_y1c     = (w_y1 > H_M1) ? H_M1 : w_y1;
  assign w_outside = (w_x0 >= W_C) || (w_y0 >= H_C);
  assign w_row0    = FBUF_ADDR_WIDTH'(w_y0) * ROW_W;
  assign w_run     = (r_state == RUN);
  assign w_load    = (r_state == SETUP) && !abort && !w_outside;

  gpu_rect_walker #(
    .COORD_WIDTH (COORD_WIDTH),
    .ADDR_WIDTH  (FBUF_ADDR_WIDTH),
    .FRAME_WIDTH (FRAME_WIDTH_SCALED)
  ) u_walker (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_load          (w_load),
    .i_x0            (w_x0),
    .i_x1            (w_x1c),
    .i_y0            (w_y0),
    .i_y1            (w_y1c),
    .i_row_base      (w_row0),
    .i_advance       (w_run && fbuf_ready),
    .i_skip_interior (r_mode == RECT_OUTLINE),
    .o_cur_x         (w_cur_x),
    .o_row_base      (w_row_base),
    .o_last          (w_last)
  );

  // State and registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic; start beats a simultaneous abort in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    w_snap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (r_l_seen && r_r_seen && r_c_seen) begin
            w_snap      = 1'b1;
            w_state_nxt = SETUP;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        if (abort) begin
          w_state_nxt = FIN;
        end else if (w_outside) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort || (fbuf_ready && w_last)) w_state_nxt = FIN;
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy       = (r_state == SETUP) || w_run;
  assign done       = (r_state == FIN);
  assign err        = r_err;
  assign fbuf_en_wr = w_run;
  assign fbuf_wrea  = w_run;
  assign fbuf_addr  = w_run ? (w_row_base + FBUF_ADDR_WIDTH'(w_cur_x)) : '0;
  assign fbuf_data  = w_run ? FBUF_DATA_WIDTH'(r_snap_col) : '0;

endmodule

// File: doc/axi4_lite_gpu_execute_rect_ext.md
Name: axi4_lite_gpu_execute_rect_ext

Overview:
Parametrised successor of the GPU rectangle executor.
- Draws an axis-aligned rectangle into the framebuffer write port in FILL or OUTLINE mode.
- Accepts corners in either order and clips them to the frame.
- Honours framebuffer backpressure and supports abort.
- Sits between the AXI4-Lite GPU register/command decoder (operand latching, start) and the framebuffer BRAM write port.

Parameters:
FRAME_WIDTH_SCALED, 640, frame width in pixels
FRAME_HEIGHT_SCALED, 480, frame height in pixels
COORD_WIDTH, 12, width of x/y operands
COLOR_WIDTH, 8, pixel colour width
FBUF_ADDR_WIDTH, 19, framebuffer address width (must hold W*H-1)
FBUF_DATA_WIDTH, 8, framebuffer data width (== COLOR_WIDTH)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  one-cycle command pulse
abort  in  1  one-cycle pulse; terminates a running command
mode  in  1  0=FILL, 1=OUTLINE; sampled with start
busy  out  1  command in progress
done  out  1  one-cycle pulse on normal completion or abort
err  out  1  one-cycle pulse on rejected command
left_valid  in  1  latch left_x/left_y
left_x, left_y  in  COORD_WIDTH  corner A
right_valid  in  1  latch right_x/right_y
right_x, right_y  in  COORD_WIDTH  corner B
color_valid  in  1  latch color
color  in  COLOR_WIDTH  draw colour
fbuf_ready  in  1  framebuffer accepts write this cycle
fbuf_en_wr  out  1  port enable
fbuf_wrea  out  1  write enable
fbuf_addr  out  FBUF_ADDR_WIDTH  y*FRAME_WIDTH_SCALED + x
fbuf_data  out  FBUF_DATA_WIDTH  pixel colour

Behaviour:
- Reset (async, rst_n=0): all outputs 0.
  - Operand registers and their "seen" flags clear.
  - FSM goes to IDLE, including when reset is asserted mid-command.
- Operand latching: each *_valid captures its data and sets its seen flag.
  - Allowed in any state.
  - A latch while busy updates the registers but does not affect the running command; the command works from snapshots taken at start.
- States: IDLE, SETUP, RUN, FIN.
- IDLE, start=1 -> SETUP:
  - Snapshot corners, colour and mode.
  - If any seen flag is 0, stay IDLE and pulse err the next cycle.
- SETUP (1 cycle, busy=1):
  - Normalise corners: x0=min, x1=max, same for y.
  - Fully outside the frame (x0>=W or y0>=H): pulse err, go to IDLE, make no writes.
  - Otherwise clip: x1=min(x1,W-1), y1=min(y1,H-1).
  - Load cur_x=x0, cur_y=y0, row_base=y0*W.
  - The y0*W multiply is a single registered multiply in SETUP; row_base then increments by W per row.
  - Go to RUN.
- RUN (busy=1):
  - fbuf_en_wr=fbuf_wrea=1, fbuf_addr=row_base+cur_x, fbuf_data=colour.
  - A pixel retires on a cycle with fbuf_ready=1; addr/data are held stable while fbuf_ready=0.
  - On retire, cur_x advances. At x1 it wraps to x0, and cur_y/row_base advance.
  - OUTLINE mode: on rows strictly between y0 and y1, cur_x jumps x0 -> x1 (only the two edge pixels are written). When x0==x1, each row has one pixel.
  - Retire of (x1,y1) -> FIN. The outline drawn is that of the clipped rectangle.
- FIN: done=1 for 1 cycle, busy=0, go to IDLE.
- Abort:
  - In SETUP or RUN: deassert write outputs next cycle, go to FIN (done pulses).
  - In IDLE: ignored.
  - Abort and start together in IDLE: start wins.
- start while busy: ignored.
- Throughput: 1 pixel/cycle while fbuf_ready=1.
- Latency: start at cycle N -> SETUP N+1 -> first write N+2.
- FILL with ready=1: done at N+2+w*h.
- Single-pixel rectangles (x0==x1, y0==y1) are legal.

Decomposition:
- Package gpu_pkg holds:
  - rect_mode_e {RECT_FILL, RECT_OUTLINE}
  - rect_state_e {IDLE, SETUP, RUN, FIN}
  - shared coordinate/colour typedefs sized by COORD_WIDTH/COLOR_WIDTH
- Sub-module gpu_rect_walker: a cur_x/cur_y/row_base raster walker with advance/skip-interior inputs and a last-pixel flag, reusable by a future line/blit engine.
- FSM, clip and operand latching stay in the top module.

Test Plan:
- FILL, left=(0,1), right=(9,10), color=0xE0, ready=1 -> exactly 100 writes, addr 640..649, 1280..1289, ... 6400..6409, data 0xE0; done at start+102; busy spans the command.
- OUTLINE, same corners -> 36 writes (rows 1 and 10 full; rows 2-9 at x=0 and x=9 only); no write at addr 1281; one done pulse.
- Reversed corners left=(9,10), right=(0,1) -> identical write sequence to the first scenario.
- Clip left=(630,470), right=(700,500) -> 100 writes, first addr 301430, last addr 307199.
- Rejection: left=(640,0), right=(700,5) -> err pulse, no fbuf_en_wr. Start with color never latched after reset -> err pulse.
- Backpressure/abort:
  - fbuf_ready toggling 1010... -> addr/data held during low cycles; 100 writes in about 200 cycles.
  - abort after 20 writes -> done pulse, no further writes.
  - rst_n low mid-RUN -> outputs 0 immediately, FSM in IDLE.
